// File: rtl/seg_scan_driver_if.sv
// Bus between the up/down counter stage and the seven-segment scan driver.
// The counter side (master) supplies the count and direction glyph; the
// driver side (slave) returns the multiplexed display drive and wrap LEDs.
interface seg_scan_driver_if;
  logic [3:0] count;
  logic [6:0] dir_seg;
  logic       dir_valid;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic [1:0] wrap_led;

  modport master (
    output count, dir_seg, dir_valid,
    input  seg, an, dp, wrap_led
  );

  modport slave (
    input  count, dir_seg, dir_valid,
    output seg, an, dp, wrap_led
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit seven-segment scan driver. Digit 0 shows the counter value as a
// hex character, digit 1 shows the direction glyph. Counter wrap-around
// (F->0 or 0->F) lights the decimal point and a wrap LED for a number of
// full display frames.
module seg_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int WRAP_HOLD      = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input logic               clk,
  input logic               rst,
  seg_scan_driver_if.slave  bus
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(WRAP_HOLD + 1);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(WRAP_HOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic          POL       = (SEG_ACTIVE_LOW != 0);

  typedef enum logic {
    SLOT_COUNT = 1'b0,
    SLOT_GLYPH = 1'b1
  } slot_t;

  logic [SW-1:0] scan_cnt;
  slot_t         slot;
  logic [3:0]    prev_cnt;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    wrap_dir;

  logic [6:0]    seg_r;
  logic [1:0]    an_r;
  logic          dp_r;
  logic [1:0]    wrap_led_r;

  logic [6:0]    hex_seg;
  logic          slot_end;
  logic          frame_end;
  logic          up_wrap;
  logic          down_wrap;
  logic          hold_active;

  // Hex character pattern for the count digit (bit 0 = segment a).
  always_comb begin
    hex_seg = 7'h00;
    case (bus.count)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
      default: hex_seg = 7'h00;
    endcase
  end

  // Slot/frame boundaries and wrap detection from the registered previous count.
  always_comb begin
    slot_end    = (scan_cnt == SCAN_LAST);
    frame_end   = slot_end && (slot == SLOT_GLYPH);
    up_wrap     = (prev_cnt == 4'hF) && (bus.count == 4'h0);
    down_wrap   = (prev_cnt == 4'h0) && (bus.count == 4'hF);
    hold_active = (hold_cnt != '0);
  end

  // Slot timer: each digit owns the display for SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      slot     <= SLOT_COUNT;
    end else if (slot_end) begin
      scan_cnt <= '0;
      slot     <= (slot == SLOT_COUNT) ? SLOT_GLYPH : SLOT_COUNT;
    end else begin
      scan_cnt <= scan_cnt + SCAN_ONE;
    end
  end

  // Previous count, compared against the live count to spot a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_cnt <= 4'h0;
    else     prev_cnt <= bus.count;
  end

  // Wrap hold: a new wrap (re)loads the frame count and wins over a frame-end decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      wrap_dir <= 2'b00;
    end else if (up_wrap || down_wrap) begin
      hold_cnt <= HOLD_LOAD;
      wrap_dir <= up_wrap ? 2'b01 : 2'b10;
    end else if (frame_end && hold_active) begin
      hold_cnt <= hold_cnt - HOLD_ONE;
      if (hold_cnt == HOLD_ONE) wrap_dir <= 2'b00;
    end
  end

  // Display registers, loaded every cycle from the current slot and inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r      <= 7'h00;
      an_r       <= 2'b00;
      dp_r       <= 1'b0;
      wrap_led_r <= 2'b00;
    end else begin
      wrap_led_r <= hold_active ? wrap_dir : 2'b00;
      if (slot == SLOT_COUNT) begin
        an_r  <= 2'b01;
        seg_r <= hex_seg;
        dp_r  <= hold_active;
      end else if (bus.dir_valid) begin
        an_r  <= 2'b10;
        seg_r <= bus.dir_seg;
        dp_r  <= 1'b0;
      end else begin
        an_r  <= 2'b00;
        seg_r <= 7'h00;
        dp_r  <= 1'b0;
      end
    end
  end

  assign bus.seg      = seg_r ^ {7{POL}};
  assign bus.an       = an_r ^ {2{POL}};
  assign bus.dp       = dp_r ^ POL;
  assign bus.wrap_led = wrap_led_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver. Two instances share the same inputs:
// one active-high, one with SEG_ACTIVE_LOW=1. Expected display values are
// pushed into a queue as each step is driven and popped after the edge.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int WH = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic [1:0] wled;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  seg_scan_driver_if bus ();
  seg_scan_driver_if bus_n ();

  assign bus_n.count     = bus.count;
  assign bus_n.dir_seg   = bus.dir_seg;
  assign bus_n.dir_valid = bus.dir_valid;

  seg_scan_driver #(.SCAN_DIV(SD), .WRAP_HOLD(WH), .SEG_ACTIVE_LOW(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seg_scan_driver #(.SCAN_DIV(SD), .WRAP_HOLD(WH), .SEG_ACTIVE_LOW(1)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t  exp_q [$];
  string tag_q [$];

  int pass_cnt  = 0;
  int check_cnt = 0;

  int         edge_n;
  int         hold_m;
  logic [1:0] dir_m;
  logic [3:0] prev_c;
  logic [3:0] cur_c;

  // Clear the reference state to match a freshly reset design.
  task automatic model_reset();
    edge_n = 0;
    hold_m = 0;
    dir_m  = 2'b00;
    prev_c = 4'h0;
  endtask

  function automatic bit next_is_slot1();
    return (((edge_n) / SD) % 2) == 1;
  endfunction

  // Drive inputs for the next edge and queue the display it must produce.
  task automatic apply_stimulus(input logic [3:0] c, input logic [6:0] g, input logic v,
                                input string tag);
    exp_t e;
    int   n;
    bit   in_slot1;
    n        = edge_n + 1;
    in_slot1 = (((n - 1) / SD) % 2) == 1;
    if (!in_slot1) begin
      e.an  = 2'b01;
      e.seg = hex_tab[c];
      e.dp  = (hold_m != 0);
    end else if (v) begin
      e.an  = 2'b10;
      e.seg = g;
      e.dp  = 1'b0;
    end else begin
      e.an  = 2'b00;
      e.seg = 7'h00;
      e.dp  = 1'b0;
    end
    e.wled = (hold_m != 0) ? dir_m : 2'b00;
    if (prev_c == 4'hF && c == 4'h0) begin
      hold_m = WH;
      dir_m  = 2'b01;
    end else if (prev_c == 4'h0 && c == 4'hF) begin
      hold_m = WH;
      dir_m  = 2'b10;
    end else if ((n % (2 * SD)) == 0 && hold_m != 0) begin
      hold_m = hold_m - 1;
      if (hold_m == 0) dir_m = 2'b00;
    end
    edge_n        = n;
    prev_c        = c;
    cur_c         = c;
    bus.count     = c;
    bus.dir_seg   = g;
    bus.dir_valid = v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Queue an all-dark expectation for a DUT held in reset.
  task automatic expect_reset(input string tag);
    exp_t e;
    e = '0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Pop one expectation and compare both instances against it.
  task automatic check_output(input bit wait_edge);
    exp_t  e;
    exp_t  e_n;
    exp_t  obs;
    exp_t  obs_n;
    string tag;
    if (wait_edge) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() == 0) begin
      check_cnt++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
      return;
    end
    e     = exp_q.pop_front();
    tag   = tag_q.pop_front();
    e_n   = '{seg: ~e.seg, an: ~e.an, dp: ~e.dp, wled: e.wled};
    obs   = '{seg: bus.seg, an: bus.an, dp: bus.dp, wled: bus.wrap_led};
    obs_n = '{seg: bus_n.seg, an: bus_n.an, dp: bus_n.dp, wled: bus_n.wrap_led};
    check_cnt++;
    assert (obs === e) pass_cnt++;
    else $error("[TB] FAIL %s edge=%0d observed seg=%h an=%b dp=%b wled=%b expected seg=%h an=%b dp=%b wled=%b",
                tag, edge_n, obs.seg, obs.an, obs.dp, obs.wled, e.seg, e.an, e.dp, e.wled);
    check_cnt++;
    assert (obs_n === e_n) pass_cnt++;
    else $error("[TB] FAIL %s_low edge=%0d observed seg=%h an=%b dp=%b wled=%b expected seg=%h an=%b dp=%b wled=%b",
                tag, edge_n, obs_n.seg, obs_n.an, obs_n.dp, obs_n.wled, e_n.seg, e_n.an, e_n.dp, e_n.wled);
  endtask

  task automatic step(input logic [3:0] c, input logic [6:0] g, input logic v,
                      input string tag);
    apply_stimulus(c, g, v, tag);
    check_output(1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.count     = 4'h5;
    bus.dir_seg   = 7'h3E;
    bus.dir_valid = 1'b1;
    cur_c         = 4'h5;
    model_reset();

    // Reset: everything dark on both instances.
    #2;
    expect_reset("reset_idle");
    check_output(1'b0);
    @(posedge clk);
    #1;
    expect_reset("reset_held");
    check_output(1'b0);
    rst = 1'b0;

    // Scan sequence: two full frames with count 5 and glyph 3E.
    for (int i = 0; i < 4 * SD; i++) step(4'h5, 7'h3E, 1'b1, "scan");

    // Hex decode sweep, each value landing in a count-digit slot.
    for (int v = 0; v < 16; v++) begin
      while (next_is_slot1()) step(cur_c, 7'h3E, 1'b1, "sweep_hold");
      step(4'(v), 7'h3E, 1'b1, "hex");
    end

    // Glyph blanking across one full frame; the count digit stays lit.
    for (int i = 0; i < 2 * SD; i++) step(cur_c, 7'h3E, 1'b0, "blank");
    for (int i = 0; i < 2; i++) step(cur_c, 7'h1C, 1'b1, "unblank");

    // Up-wrap E -> F -> 0, then the hold expires; 0 -> 1 raises nothing.
    step(4'hE, 7'h1C, 1'b1, "upwrap_e");
    step(4'hF, 7'h1C, 1'b1, "upwrap_f");
    step(4'h0, 7'h1C, 1'b1, "upwrap_0");
    for (int i = 0; i < 5 * SD; i++) step(4'h0, 7'h1C, 1'b1, "up_hold");
    for (int i = 0; i < SD; i++) step(4'h1, 7'h1C, 1'b1, "no_wrap");

    // Down-wrap 0 -> F, then an up-wrap one frame later retriggers the hold.
    step(4'h0, 7'h1C, 1'b1, "dn_pre");
    step(4'hF, 7'h1C, 1'b1, "dn_wrap");
    for (int i = 0; i < 2 * SD; i++) step(4'hF, 7'h1C, 1'b1, "dn_hold");
    step(4'h0, 7'h1C, 1'b1, "retrig");
    for (int i = 0; i < 5 * SD; i++) step(4'h0, 7'h1C, 1'b1, "re_hold");

    // Reset mid-hold and mid-slot clears outputs without waiting for an edge.
    step(4'hF, 7'h1C, 1'b1, "pre_rst_wrap");
    for (int i = 0; i < 2; i++) step(4'hF, 7'h1C, 1'b1, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    expect_reset("async_rst");
    check_output(1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Scanning restarts at slot 0; count F against a cleared prev is a down-wrap.
    for (int i = 0; i < 3 * SD; i++) step(4'hF, 7'h1C, 1'b1, "restart");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
